// File: rtl/tchk_cond_monitor.sv
// tchk_cond_monitor: clocked, multi-channel conditional setup/hold monitor.
// Each data channel is watched against one shared reference strobe that is
// qualified by cond. Violations are reported as registered one-cycle pulses,
// a per-channel toggling notifier and saturating per-channel counters.
module tchk_cond_monitor #(
    parameter int NCH       = 2,
    parameter int SETUP_CYC = 4,
    parameter int HOLD_CYC  = 3,
    parameter int CNT_W     = 8,
    parameter int DATA_EDGE = 0,
    parameter int REF_EDGE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       data,
    input  logic                 ref_sig,
    input  logic                 cond,
    input  logic                 clr,
    output logic [NCH-1:0]       viol_setup,
    output logic [NCH-1:0]       viol_hold,
    output logic [NCH-1:0]       notifier,
    output logic [NCH*CNT_W-1:0] viol_cnt
);

    localparam int AGE_W = $clog2(SETUP_CYC + 1);
    localparam int HC_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(SETUP_CYC);
    localparam logic [HC_W-1:0]  HC_LAST = HC_W'(HOLD_CYC - 1);

    typedef enum logic {
        H_IDLE = 1'b0,
        H_WIN  = 1'b1
    } hstate_t;

    // Edge selector: mode 0 falling, 1 rising, anything else either edge.
    function automatic logic edge_of(input logic prev, input logic cur, input int mode);
        logic e;
        case (mode)
            0:       e = prev & ~cur;
            1:       e = ~prev & cur;
            default: e = prev ^ cur;
        endcase
        return e;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + (CNT_W+1)'(inc);
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    logic                 armed_r;
    logic [NCH-1:0]       data_prev_r;
    logic                 ref_prev_r;
    logic [AGE_W-1:0]     age_r      [NCH];
    hstate_t              hstate_r   [NCH];
    logic [HC_W-1:0]      hcnt_r     [NCH];
    logic [NCH-1:0]       viol_setup_r;
    logic [NCH-1:0]       viol_hold_r;
    logic [NCH-1:0]       notifier_r;
    logic [NCH*CNT_W-1:0] viol_cnt_r;

    logic                 qr_s;
    logic [NCH-1:0]       dedge_s;
    logic [NCH-1:0]       setup_s;
    logic [NCH-1:0]       hold_s;
    logic [AGE_W-1:0]     age_nxt_s  [NCH];
    hstate_t              hstate_nxt_s [NCH];
    logic [HC_W-1:0]      hcnt_nxt_s [NCH];
    logic [NCH*CNT_W-1:0] cnt_nxt_s;

    // Qualified reference edge; an unknown or low cond never qualifies.
    always_comb begin
        qr_s = 1'b0;
        if (armed_r && edge_of(ref_prev_r, ref_sig, REF_EDGE) && (cond === 1'b1)) begin
            qr_s = 1'b1;
        end else begin
            qr_s = 1'b0;
        end
    end

    // Per-channel edge detect, setup age, hold window and counter next-state.
    always_comb begin
        dedge_s   = '0;
        setup_s   = '0;
        hold_s    = '0;
        cnt_nxt_s = viol_cnt_r;
        for (int i = 0; i < NCH; i++) begin
            age_nxt_s[i]    = age_r[i];
            hstate_nxt_s[i] = hstate_r[i];
            hcnt_nxt_s[i]   = hcnt_r[i];

            dedge_s[i] = armed_r & edge_of(data_prev_r[i], data[i], DATA_EDGE);

            // Age as seen in this cycle: a same-cycle data edge means age 0.
            if (dedge_s[i]) begin
                age_nxt_s[i] = {AGE_W{1'b0}};
            end else if (age_r[i] == AGE_MAX) begin
                age_nxt_s[i] = AGE_MAX;
            end else begin
                age_nxt_s[i] = age_r[i] + AGE_W'(1);
            end

            setup_s[i] = qr_s & (age_nxt_s[i] < AGE_MAX);
            hold_s[i]  = dedge_s[i] & (qr_s | (hstate_r[i] == H_WIN));

            // The QR cycle itself is window offset 0, so WIN starts at 1.
            case (hstate_r[i])
                H_IDLE: begin
                    if (qr_s && (HOLD_CYC > 1)) begin
                        hstate_nxt_s[i] = H_WIN;
                        hcnt_nxt_s[i]   = HC_W'(1);
                    end else begin
                        hstate_nxt_s[i] = H_IDLE;
                        hcnt_nxt_s[i]   = {HC_W{1'b0}};
                    end
                end
                H_WIN: begin
                    if (qr_s) begin
                        hstate_nxt_s[i] = H_WIN;
                        hcnt_nxt_s[i]   = HC_W'(1);
                    end else if (hcnt_r[i] == HC_LAST) begin
                        hstate_nxt_s[i] = H_IDLE;
                        hcnt_nxt_s[i]   = {HC_W{1'b0}};
                    end else begin
                        hstate_nxt_s[i] = H_WIN;
                        hcnt_nxt_s[i]   = hcnt_r[i] + HC_W'(1);
                    end
                end
                default: begin
                    hstate_nxt_s[i] = H_IDLE;
                    hcnt_nxt_s[i]   = {HC_W{1'b0}};
                end
            endcase

            if (clr) begin
                cnt_nxt_s[i*CNT_W +: CNT_W] = CNT_W'({1'b0, setup_s[i]} + {1'b0, hold_s[i]});
            end else begin
                cnt_nxt_s[i*CNT_W +: CNT_W] = sat_add(viol_cnt_r[i*CNT_W +: CNT_W],
                                                      {1'b0, setup_s[i]} + {1'b0, hold_s[i]});
            end
        end
    end

    // State and registered outputs; reset discards all history immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r      <= 1'b0;
            data_prev_r  <= '0;
            ref_prev_r   <= 1'b0;
            viol_setup_r <= '0;
            viol_hold_r  <= '0;
            notifier_r   <= '0;
            viol_cnt_r   <= '0;
            for (int i = 0; i < NCH; i++) begin
                age_r[i]    <= AGE_MAX;
                hstate_r[i] <= H_IDLE;
                hcnt_r[i]   <= {HC_W{1'b0}};
            end
        end else begin
            armed_r      <= 1'b1;
            data_prev_r  <= data;
            ref_prev_r   <= ref_sig;
            viol_setup_r <= setup_s;
            viol_hold_r  <= hold_s;
            notifier_r   <= notifier_r ^ (setup_s | hold_s);
            viol_cnt_r   <= cnt_nxt_s;
            for (int i = 0; i < NCH; i++) begin
                age_r[i]    <= age_nxt_s[i];
                hstate_r[i] <= hstate_nxt_s[i];
                hcnt_r[i]   <= hcnt_nxt_s[i];
            end
        end
    end

    assign viol_setup = viol_setup_r;
    assign viol_hold  = viol_hold_r;
    assign notifier   = notifier_r;
    assign viol_cnt   = viol_cnt_r;

endmodule

// File: tb/tb_tchk_cond_monitor.sv
// Scoreboard bench for tchk_cond_monitor (default parameters).
module tb_tchk_cond_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  data;
    logic        ref_sig;
    logic        cond;
    logic        clr;
    logic [1:0]  viol_setup;
    logic [1:0]  viol_hold;
    logic [1:0]  notifier;
    logic [15:0] viol_cnt;

    tchk_cond_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .ref_sig    (ref_sig),
        .cond       (cond),
        .clr        (clr),
        .viol_setup (viol_setup),
        .viol_hold  (viol_hold),
        .notifier   (notifier),
        .viol_cnt   (viol_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [1:0]  su;
        logic [1:0]  ho;
        logic [1:0]  nt;
        logic [15:0] cnt;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    logic [1:0] m_nt;
    int         m_cnt [2];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs being driven now are sampled at posedge cyc+1; the pulse is seen then.
    task automatic expect_ev(input logic [1:0] su, input logic [1:0] ho, input bit clr_now);
        exp_t e;
        int   n;
        for (int i = 0; i < 2; i++) begin
            n = int'(su[i]) + int'(ho[i]);
            if (n > 0) m_nt[i] = ~m_nt[i];
            if (clr_now) m_cnt[i] = n;
            else m_cnt[i] = (m_cnt[i] + n > 255) ? 255 : m_cnt[i] + n;
        end
        e.cyc = cyc + 1;
        e.su  = su;
        e.ho  = ho;
        e.nt  = m_nt;
        e.cnt = {8'(m_cnt[1]), 8'(m_cnt[0])};
        q.push_back(e);
    endtask

    task automatic model_clr();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    // Monitor: every pulse must match the oldest expectation, in the right cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse: expected pulse at cycle %0d absent (now %0d)", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if ((viol_setup | viol_hold) != 2'b00) begin
            if (q.size() == 0 || q[0].cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: setup=%b hold=%b at cycle %0d, required none",
                         viol_setup, viol_hold, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("pulse_setup",    {30'd0, viol_setup}, {30'd0, mon_e.su});
                chk("pulse_hold",     {30'd0, viol_hold},  {30'd0, mon_e.ho});
                chk("pulse_notifier", {30'd0, notifier},   {30'd0, mon_e.nt});
                chk("pulse_cnt",      {16'd0, viol_cnt},   {16'd0, mon_e.cnt});
            end
        end
    end

    initial begin
        data    = 2'b11;
        ref_sig = 1'b1;
        cond    = 1'b1;
        clr     = 1'b0;
        rst_n   = 1'b0;
        m_nt    = 2'b00;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        tick(3);
        chk("reset_setup",    {30'd0, viol_setup}, 32'd0);
        chk("reset_hold",     {30'd0, viol_hold},  32'd0);
        chk("reset_notifier", {30'd0, notifier},   32'd0);
        chk("reset_cnt",      {16'd0, viol_cnt},   32'd0);
        rst_n = 1'b1;
        tick(6);

        // Setup hit: data[0] falls, ref falls 2 cycles later.
        data[0] = 1'b0;
        tick(2);
        ref_sig = 1'b0;
        expect_ev(2'b01, 2'b00, 1'b0);
        tick(1);
        ref_sig = 1'b1;
        data[0] = 1'b1;
        tick(6);
        chk("setup_hit_cnt",      {16'd0, viol_cnt}, 32'h0001);
        chk("setup_hit_notifier", {30'd0, notifier}, 32'h1);

        // Same stimulus with cond low at the ref edge: nothing.
        data[0] = 1'b0;
        tick(2);
        ref_sig = 1'b0;
        cond    = 1'b0;
        tick(1);
        ref_sig = 1'b1;
        cond    = 1'b1;
        data[0] = 1'b1;
        tick(6);
        chk("cond_gate_cnt", {16'd0, viol_cnt}, 32'h0001);

        // Data edge exactly SETUP_CYC before the ref edge: no violation.
        data[0] = 1'b0;
        tick(4);
        ref_sig = 1'b0;
        tick(1);
        ref_sig = 1'b1;
        data[0] = 1'b1;
        tick(6);
        chk("setup_edge4_cnt", {16'd0, viol_cnt}, 32'h0001);

        // Hold hit: QR then data[1] falls 2 cycles later.
        ref_sig = 1'b0;
        tick(1);
        ref_sig = 1'b1;
        tick(1);
        data[1] = 1'b0;
        expect_ev(2'b00, 2'b10, 1'b0);
        tick(1);
        data[1] = 1'b1;
        tick(6);
        chk("hold_hit_cnt",      {16'd0, viol_cnt}, 32'h0101);
        chk("hold_hit_notifier", {30'd0, notifier}, 32'h3);

        // Data edge 3 cycles after QR lies outside the hold window.
        ref_sig = 1'b0;
        tick(1);
        ref_sig = 1'b1;
        tick(2);
        data[1] = 1'b0;
        tick(1);
        data[1] = 1'b1;
        tick(6);
        chk("hold_edge3_cnt", {16'd0, viol_cnt}, 32'h0101);

        // Simultaneous data and ref edge: setup and hold, notifier flips once.
        data[0] = 1'b0;
        ref_sig = 1'b0;
        expect_ev(2'b01, 2'b01, 1'b0);
        tick(1);
        data[0] = 1'b1;
        ref_sig = 1'b1;
        tick(6);
        chk("simul_cnt",      {16'd0, viol_cnt}, 32'h0103);
        chk("simul_notifier", {30'd0, notifier}, 32'h2);

        // 300 setup violations on ch0 drive the counter into saturation.
        for (int k = 0; k < 300; k++) begin
            data[0] = 1'b0;
            tick(1);
            ref_sig = 1'b0;
            expect_ev(2'b01, 2'b00, 1'b0);
            tick(1);
            data[0] = 1'b1;
            ref_sig = 1'b1;
            tick(2);
        end
        tick(4);
        chk("sat_cnt", {16'd0, viol_cnt}, 32'h01FF);

        // clr alone zeroes both counters and leaves notifier alone.
        clr = 1'b1;
        model_clr();
        tick(1);
        clr = 1'b0;
        tick(2);
        chk("clr_alone_cnt",      {16'd0, viol_cnt}, 32'h0000);
        chk("clr_alone_notifier", {30'd0, notifier}, {30'd0, m_nt});

        // clr in a violating cycle loads the new violation count.
        data[0] = 1'b0;
        tick(1);
        ref_sig = 1'b0;
        clr     = 1'b1;
        expect_ev(2'b01, 2'b00, 1'b1);
        tick(1);
        clr     = 1'b0;
        ref_sig = 1'b1;
        data[0] = 1'b1;
        tick(6);
        chk("clr_viol_cnt", {16'd0, viol_cnt}, 32'h0001);

        // Reset inside the hold window, data edge during reset.
        ref_sig = 1'b0;
        tick(1);
        ref_sig = 1'b1;
        rst_n   = 1'b0;
        m_nt    = 2'b00;
        model_clr();
        data[1] = 1'b0;
        tick(2);
        chk("midrst_setup",    {30'd0, viol_setup}, 32'd0);
        chk("midrst_hold",     {30'd0, viol_hold},  32'd0);
        chk("midrst_notifier", {30'd0, notifier},   32'd0);
        chk("midrst_cnt",      {16'd0, viol_cnt},   32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("release_pulses",   {28'd0, viol_setup, viol_hold}, 32'd0);
        chk("release_notifier", {30'd0, notifier},              32'd0);
        tick(5);
        chk("release_cnt",      {16'd0, viol_cnt},              32'd0);
        chk("release_notifier2", {30'd0, notifier},             32'd0);
        chk("pending_expect", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
